// File: rtl/move_pkg.sv
// Shared definitions for the move sequencer: FSM state encoding, direction
// indices into the 4-bit direction vectors, and the priority picker.
package move_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    SETTLE = 2'd2,
    LOCK   = 2'd3
  } seqState_t;

  localparam int unsigned DIR_W     = 4;
  // Index order doubles as priority order: lowest index wins.
  localparam int unsigned DIR_DOWN  = 0;
  localparam int unsigned DIR_LEFT  = 1;
  localparam int unsigned DIR_RIGHT = 2;
  localparam int unsigned DIR_UP    = 3;

  // One-hot of the lowest set bit (down > left > right > up).
  function automatic logic [DIR_W-1:0] pickHighest(input logic [DIR_W-1:0] v);
    return v & (~v + DIR_W'(1));
  endfunction

endpackage

// File: rtl/repeat_timer.sv
// Turns held-button levels into request pulses: one pulse per rising edge,
// plus auto-repeat for the highest-priority held button (first after
// REPEAT_DELAY cycles, then every REPEAT_RATE cycles).
// Ports: clk, rst (sync, active-high), held[3:0] button levels,
//        reqPulse_c[3:0] combinational one-cycle request pulses.
module repeat_timer
  import move_pkg::*;
#(
  parameter int unsigned REPEAT_DELAY = 15000000,
  parameter int unsigned REPEAT_RATE  = 5000000,
  parameter int unsigned CNT_W        = 26
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DIR_W-1:0] held,
  output logic [DIR_W-1:0] reqPulse_c
);

  logic [DIR_W-1:0] heldPrev;
  logic [CNT_W-1:0] repCnt;
  logic             inRate;
  logic             heldChanged;
  logic             cntHit;

  assign heldChanged = (held != heldPrev);
  assign cntHit = inRate ? (repCnt == CNT_W'(REPEAT_RATE - 1))
                         : (repCnt == CNT_W'(REPEAT_DELAY - 1));

  // Press edges for every button; repeat only for the top held one.
  always_comb begin
    reqPulse_c = held & ~heldPrev;
    if (!heldChanged && (held != '0) && cntHit) begin
      reqPulse_c = reqPulse_c | pickHighest(held);
    end
  end

  // Counter restarts whenever the held set changes or nothing is held.
  always_ff @(posedge clk) begin
    if (rst) begin
      heldPrev <= '0;
      repCnt   <= '0;
      inRate   <= 1'b0;
    end else begin
      heldPrev <= held;
      if (heldChanged || (held == '0)) begin
        repCnt <= '0;
        inRate <= 1'b0;
      end else if (cntHit) begin
        repCnt <= '0;
        inRate <= 1'b1;
      end else begin
        repCnt <= repCnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/move_sequencer.sv
// Arbitrates gravity and button move requests for the active piece and
// issues one registered move strobe at a time, or a lock strobe when
// gravity fires while down is not legal.
// Ports: clk, rst (sync, active-high); btn_* debounced buttons;
//        *Enable_i move-legal flags; pause freezes gravity and drops requests;
//        move_* one-cycle move strobes; lock_piece one-cycle landed strobe;
//        state_o current FSM state (debug).
module move_sequencer
  import move_pkg::*;
#(
  parameter int unsigned TICK_DIV     = 50000000,
  parameter int unsigned REPEAT_DELAY = 15000000,
  parameter int unsigned REPEAT_RATE  = 5000000,
  parameter int unsigned SETTLE_CYC   = 2,
  parameter int unsigned CNT_W        = 26
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       upEnable_i,
  input  logic       downEnable_i,
  input  logic       leftEnable_i,
  input  logic       rightEnable_i,
  input  logic       pause,
  output logic       move_up,
  output logic       move_down,
  output logic       move_left,
  output logic       move_right,
  output logic       lock_piece,
  output logic [1:0] state_o
);

  localparam int unsigned SETTLE_W = $clog2(SETTLE_CYC + 1);

  seqState_t        state, stateNext;
  logic [DIR_W-1:0] btnVec, enVec, reqPulse_c, reqSet, reqLatch, reqClr;
  logic [DIR_W-1:0] selDir, selDirNext, moveReg, moveNext;
  logic             selGravity, selGravityNext;
  logic [SETTLE_W-1:0] settleCnt, settleNext;
  logic [CNT_W-1:0] gravCnt;
  logic             gravWrap, gravityPending, gravClr;
  logic             lockReg, lockNext;

  always_comb begin
    btnVec            = '0;
    btnVec[DIR_DOWN]  = btn_down;
    btnVec[DIR_LEFT]  = btn_left;
    btnVec[DIR_RIGHT] = btn_right;
    btnVec[DIR_UP]    = btn_up;
    enVec             = '0;
    enVec[DIR_DOWN]   = downEnable_i;
    enVec[DIR_LEFT]   = leftEnable_i;
    enVec[DIR_RIGHT]  = rightEnable_i;
    enVec[DIR_UP]     = upEnable_i;
  end

  repeat_timer #(
    .REPEAT_DELAY(REPEAT_DELAY),
    .REPEAT_RATE (REPEAT_RATE),
    .CNT_W       (CNT_W)
  ) uRepeat (
    .clk       (clk),
    .rst       (rst),
    .held      (btnVec),
    .reqPulse_c(reqPulse_c)
  );

  assign reqSet   = pause ? '0 : reqPulse_c;
  assign gravWrap = !pause && (gravCnt == CNT_W'(TICK_DIV - 1));

  // Gravity tick and pending flag; a new tick wins over a same-cycle clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      gravCnt        <= '0;
      gravityPending <= 1'b0;
    end else begin
      if (gravWrap) begin
        gravCnt <= '0;
      end else if (!pause) begin
        gravCnt <= gravCnt + CNT_W'(1);
      end
      if (gravWrap) begin
        gravityPending <= 1'b1;
      end else if (gravClr) begin
        gravityPending <= 1'b0;
      end
    end
  end

  // Request latches merge repeats; a new request wins over a same-cycle clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      reqLatch <= '0;
    end else begin
      reqLatch <= (reqLatch & ~reqClr) | reqSet;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      selGravity <= 1'b0;
      selDir     <= '0;
      settleCnt  <= '0;
      moveReg    <= '0;
      lockReg    <= 1'b0;
    end else begin
      state      <= stateNext;
      selGravity <= selGravityNext;
      selDir     <= selDirNext;
      settleCnt  <= settleNext;
      moveReg    <= moveNext;
      lockReg    <= lockNext;
    end
  end

  // Next-state and next-output logic; requests are consumed at selection.
  always_comb begin
    stateNext      = state;
    selGravityNext = selGravity;
    selDirNext     = selDir;
    settleNext     = settleCnt;
    moveNext       = '0;
    lockNext       = 1'b0;
    reqClr         = '0;
    gravClr        = 1'b0;
    case (state)
      IDLE: begin
        if (pause) begin
          reqClr  = '1;
          gravClr = 1'b1;
        end else if (gravityPending) begin
          // Gravity also absorbs a pending manual down: one move, not two.
          selGravityNext       = 1'b1;
          selDirNext           = '0;
          selDirNext[DIR_DOWN] = 1'b1;
          reqClr[DIR_DOWN]     = 1'b1;
          gravClr              = 1'b1;
          stateNext            = ISSUE;
        end else if (reqLatch != '0) begin
          selGravityNext = 1'b0;
          selDirNext     = pickHighest(reqLatch);
          reqClr         = pickHighest(reqLatch);
          stateNext      = ISSUE;
        end
      end
      ISSUE: begin
        if (selGravity && !downEnable_i) begin
          stateNext = LOCK;
        end else if ((selDir & enVec) != '0) begin
          moveNext   = selDir;
          settleNext = '0;
          stateNext  = SETTLE;
        end else begin
          stateNext = IDLE;
        end
      end
      LOCK: begin
        lockNext   = 1'b1;
        reqClr     = '1;
        gravClr    = 1'b1;
        settleNext = '0;
        stateNext  = SETTLE;
      end
      SETTLE: begin
        if (settleCnt == SETTLE_W'(SETTLE_CYC - 1)) begin
          stateNext = IDLE;
        end else begin
          settleNext = settleCnt + SETTLE_W'(1);
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  assign move_down  = moveReg[DIR_DOWN];
  assign move_left  = moveReg[DIR_LEFT];
  assign move_right = moveReg[DIR_RIGHT];
  assign move_up    = moveReg[DIR_UP];
  assign lock_piece = lockReg;
  assign state_o    = state;

endmodule
